// File: rtl/mips_pkg.sv
// mips_pkg: shared op/state encodings and iteration count for the multiply/divide unit
package mips_pkg;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX} md_state_t;
  localparam int MD_ITER = 32;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step #(
  parameter int w = 32
) (
  input  logic           div,
  input  logic [2*w-1:0] acc,
  input  logic [w-1:0]   opnd,
  output logic [2*w-1:0] acc_n
);
  logic [w:0] sum, diff;
  assign sum   = {1'b0, acc[2*w-1:w]} + (acc[0] ? {1'b0, opnd} : '0);
  assign diff  = acc[2*w-1:w-1] - {1'b0, opnd};
  assign acc_n = div ? (diff[w] ? {acc[2*w-2:0], 1'b0} : {diff[w-1:0], acc[w-2:0], 1'b1})
                     : {sum, acc[w-1:1]};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int num_bit = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [num_bit-1:0] data1,
  input  logic [num_bit-1:0] data2,
  input  logic               mthi,
  input  logic               mtlo,
  input  logic [num_bit-1:0] wdata,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [num_bit-1:0] hi,
  output logic [num_bit-1:0] lo
);
  localparam int w = num_bit;
  md_state_t state, state_n;
  logic [5:0] cnt;
  logic [2*w-1:0] acc, acc_n, prod;
  logic [w-1:0] opnd, a1, a2, q_fix, r_fix;
  logic is_div, sgn, dz_in, div_q, dz_q, s1, s2;
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign dz_in  = is_div && (data2 == '0);
  assign a1     = (sgn && data1[w-1]) ? -data1 : data1;
  assign a2     = (sgn && data2[w-1]) ? -data2 : data2;
  assign prod   = (s1 ^ s2) ? -acc : acc;
  assign q_fix  = (s1 ^ s2) ? -acc[w-1:0] : acc[w-1:0];
  assign r_fix  = s1 ? -acc[2*w-1:w] : acc[2*w-1:w];
  assign busy   = state != MD_IDLE;
  muldiv_step #(.w(w)) u_step (.div(div_q), .acc(acc), .opnd(opnd), .acc_n(acc_n));
  always_ff @(posedge clk)
    if (!rst) state <= MD_IDLE;
    else      state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == MD_IDLE ? (start ? (dz_in ? MD_FIX : MD_CALC) : MD_IDLE)
            : state == MD_CALC ? (cnt == 6'(MD_ITER - 1) ? MD_FIX : MD_CALC)
            : MD_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      div_q <= 1'b0;
      dz_q <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      if (state == MD_IDLE) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
        if (start) begin
          div_q <= is_div;
          dz_q <= dz_in;
          s1 <= sgn && data1[w-1];
          s2 <= sgn && data2[w-1];
          div_by_zero <= 1'b0;
          cnt <= '0;
          acc <= {{w{1'b0}}, dz_in ? data1 : a1};
          opnd <= a2;
        end
      end else if (state == MD_CALC) begin
        acc <= acc_n;
        cnt <= cnt + 6'd1;
      end else begin
        done <= 1'b1;
        div_by_zero <= dz_q;
        hi <= dz_q ? acc[w-1:0] : div_q ? r_fix : prod[2*w-1:w];
        lo <= dz_q ? '1 : div_q ? q_fix : prod[w-1:0];
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] data1 = '0, data2 = '0, wdata = '0;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  muldiv_unit #(.num_bit(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .data1(data1), .data2(data2),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    int da, db;
    ez = 1'b0;
    eh = '0;
    el = '0;
    if (o == 2'b00) begin
      sa = int'(a);
      sb = int'(b);
      p = sa * sb;
      {eh, el} = p;
    end else if (o == 2'b01) begin
      ua = a;
      ub = b;
      up = ua * ub;
      {eh, el} = up;
    end else if (b == 0) begin
      ez = 1'b1;
      eh = a;
      el = 32'hFFFF_FFFF;
    end else if (o == 2'b10) begin
      da = int'(a);
      db = int'(b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        el = 32'h8000_0000;
        eh = 0;
      end else begin
        el = da / db;
        eh = da % db;
      end
    end else begin
      el = a / b;
      eh = a % b;
    end
  endfunction
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int poke, input logic mt_en, input logic [31:0] mt_val);
    logic [31:0] eh, el;
    logic ez;
    int n, bc, lat;
    model(o, a, b, eh, el, ez);
    lat = ez ? 1 : 33;
    @(negedge clk);
    start = 1'b1;
    op = o;
    data1 = a;
    data2 = b;
    mthi = mt_en;
    wdata = mt_val;
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi = 1'b0;
    if (mt_en) chk({tag, " mthi_with_start"}, hi, mt_val);
    chk({tag, " dbz_cleared"}, {31'b0, div_by_zero}, 32'd0);
    n = 0;
    bc = 0;
    while (!done && n < 200) begin
      if (busy) bc++;
      start = (n == poke);
      data1 = $urandom;
      data2 = $urandom;
      op = 2'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy_cycles"}, bc, lat);
    chk({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    chk({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
  endtask
  initial begin
    int dn;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst dbz", {31'b0, div_by_zero}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    rst = 1'b1;
    do_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, -1, 1'b0, 0);
    chk("mult_m3x5 hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_m3x5 lo_const", lo, 32'hFFFF_FFF1);
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 0);
    chk("multu_max hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_max lo_const", lo, 32'h0000_0001);
    do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, 0);
    chk("div_m7_2 lo_const", lo, 32'hFFFF_FFFD);
    chk("div_m7_2 hi_const", hi, 32'hFFFF_FFFF);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, 0);
    chk("div_ovf lo_const", lo, 32'h8000_0000);
    do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 10, 1'b0, 0);
    chk("divu_100_7 lo_const", lo, 32'd14);
    chk("divu_100_7 hi_const", hi, 32'd2);
    do_op("divu_zero", 2'b11, 32'd1234, 32'd0, -1, 1'b0, 0);
    chk("divu_zero flag_const", {31'b0, div_by_zero}, 32'd1);
    do_op("mult_after_dz", 2'b00, 32'd7, 32'hFFFF_FFFE, -1, 1'b0, 0);
    do_op("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'd0, -1, 1'b0, 0);
    do_op("multu_mthi", 2'b01, 32'd3, 32'd4, -1, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    start = 1'b1;
    op = 2'b00;
    data1 = 32'h1234_5678;
    data2 = 32'h0000_0099;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    rst = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) dn++;
    end
    chk("midrst no_done", dn, 0);
    @(negedge clk);
    mtlo = 1'b1;
    wdata = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    mtlo = 1'b0;
    chk("mtlo lo", lo, 32'h0000_ABCD);
    chk("mtlo hi_kept", hi, 32'd0);
    @(negedge clk);
    mthi = 1'b1;
    wdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    chk("mthi hi", hi, 32'h5555_AAAA);
    chk("mthi lo_kept", lo, 32'h0000_ABCD);
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      do_op($sformatf("rand%0d", i), ro, ra, rb, $urandom_range(0, 40), 1'b0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the EX stage of the MIPS pipeline, in parallel with the ALU. It takes the same two operands the ALU receives from the ID/EX register and executes MULT, MULTU, DIV and DIVU over multiple cycles. Results are held in internal HI/LO registers, which the pipeline reads for MFHI/MFLO and writes with MTHI/MTLO. `busy` is the stall request to the hazard logic.

## Interface
Parameters:
- `num_bit`, 32, operand/result width; only 32 is verified.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of `clk`.
- `start`  in  1  launch request; accepted only when idle.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `data1`  in  32  rs operand (multiplicand/dividend).
- `data2`  in  32  rt operand (multiplier/divisor).
- `mthi`, `mtlo`  in  1 each  direct write of `wdata` into HI/LO.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO valid this cycle.
- `div_by_zero`  out  1  set with `done` of a DIV/DIVU whose divisor is 0; held until the next accepted `start`.
- `hi`, `lo`  out  32 each  HI/LO registers.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + `start`:
  - latch `op`;
  - signed ops load |data1|, |data2| and record the operand signs;
  - clear `div_by_zero`;
  - 6-bit counter = 0;
  - go to CALC.
- Divide by zero: DIV/DIVU with `data2`==0 skips CALC.
  - Next edge: HI=data1, LO=32'hFFFF_FFFF, `div_by_zero`=1, `done`=1, return to IDLE.
- CALC: one radix-2 step per cycle for 32 cycles.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; quotient in the low half, remainder in the high half.
  - After the step with counter==31, go to FIX.
- FIX: apply sign correction, write HI/LO, pulse `done`, return to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ. HI=product[63:32], LO=product[31:0].
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend. LO=quotient, HI=remainder.
  - -2^31 / -1 gives LO=32'h8000_0000, HI=0, with no flag and no trap.
  - Unsigned ops: no correction.
- `start` while `busy`: ignored; the operation in flight is unaffected.
- `mthi`/`mtlo` in IDLE: write `wdata` on the edge.
  - If `start` arrives in the same cycle, both happen; the later result overwrites.
  - Ignored while `busy`.
- HI/LO change only on FIX, the divide-by-zero shortcut, MTHI/MTLO, or reset.

## Timing
- Reset (`rst`=0 at an edge), from any state including mid-operation:
  - state IDLE, counter 0;
  - `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0;
  - accumulator discarded.
- Normal latency, with `start` accepted at edge E0:
  - `busy`=1 after E0;
  - CALC occupies edges E1..E32;
  - FIX result is written at E33, with `done`=1 and `busy`=0 after E33 for exactly one cycle.
- Back-to-back: a new `start` may be sampled in the same cycle `done`=1.
- Divide-by-zero latency: result and `done` after E1; `busy` is high for one cycle.
- `busy`, `done`, `hi` and `lo` are all registered outputs with no combinational path from the inputs.

## Structure
- Shared package `mips_pkg`:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - state encodings `MD_IDLE`, `MD_CALC`, `MD_FIX`;
  - constant `MD_ITER`=32.
- Sub-module `muldiv_step`: combinational single-iteration datapath.
  - Inputs: mode (mul/div), 64-bit accumulator, 32-bit operand.
  - Output: next 64-bit accumulator.
  - The top level holds the FSM, counter, sign flags and HI/LO.

## Test plan
- MULT, data1=-3 (FFFFFFFD), data2=5 → at E33 `done`=1, HI=FFFFFFFF, LO=FFFFFFF1; `busy` high for exactly 33 cycles.
- MULTU FFFFFFFF×FFFFFFFF → HI=FFFFFFFE, LO=00000001.
- Signed divide:
  - DIV -7/2 → LO=FFFFFFFD, HI=FFFFFFFF.
  - DIV 80000000/FFFFFFFF → LO=80000000, HI=0, `div_by_zero`=0.
- DIVU 100/7 → LO=14, HI=2. A second `start` asserted at cycle 10 of that divide is ignored and the result is unchanged.
- DIVU 1234/0 → `done` after E1, HI=1234, LO=FFFFFFFF, `div_by_zero`=1. The next MULT clears the flag.
- Reset mid-operation: `rst`=0 at cycle 10 of a MULT → `busy`=0, HI=LO=0, no `done` pulse. Then MTLO 0000ABCD in IDLE → LO=0000ABCD on the next edge.
